// File: rtl/mod_half_scale.sv
// mod_half_scale
//
// Multiplies an operand by 2^-k modulo an odd modulus p by applying k
// modular halvings, one per clock. Used for INTT output scaling by N^-1 mod p.
// Operations are accepted through a valid/ready input handshake, and the
// result is presented through a valid/ready output handshake.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers an operation
//   in_ready   high only in IDLE; an operation is accepted on in_valid & in_ready
//   in_data    operand x (x < p guaranteed upstream)
//   in_p       odd modulus p, p >= 3
//   in_k       number of halvings, unsigned
//   out_valid  result available (DONE)
//   out_ready  downstream accepts the result
//   out_data   result x * 2^-k mod p, in [0, p), registered
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready=1
// RUN   | one halving per cycle, cnt counts the halvings still to do
// DONE  | result held on out_data until out_ready

`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module mod_half_scale #(
    parameter int DW = `DATAWIDTH,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_p,
    input  logic [CW-1:0] in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // x + p can reach 2p-1, so the sum keeps one extra bit for the carry.
    logic [DW:0]   sum;
    logic [DW-1:0] half;

    assign sum  = {1'b0, x_q} + {1'b0, p_q};
    assign half = x_q[0] ? DW'(sum >> 1) : DW'(x_q >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    p_d     = in_p;
                    cnt_d   = in_k;
                    state_d = (in_k != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                x_d   = half;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs come straight from state registers.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = x_q;

endmodule

// File: doc/mod_half_scale.md
MOD_HALF_SCALE -- requirements
Module: mod_half_scale

Interface
REQ-001 Parameter: DW, default `datawidth (from ntt_define.vh), datapath width of operands, modulus and result.
REQ-002 Parameter: CW, default 5, width of the halving-count input k.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream offers an operation.
REQ-006 Port: in_ready  output  1  block can accept an operation.
REQ-007 Port: in_data  input  DW  operand x; upstream guarantees x < p.
REQ-008 Port: in_p  input  DW  odd modulus p, p >= 3.
REQ-009 Port: in_k  input  CW  number of modular halvings (result = x * 2^-k mod p).
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_data  output  DW  result, in [0, p).

Function
REQ-013 Purpose: INTT output scaling by N^-1 mod p; the block SHALL apply k modular halvings, one per cycle.
REQ-014 One halving SHALL be: x even -> x>>1; x odd -> ({1'b0,x}+{1'b0,p})>>1, sum computed at DW+1 bits so the carry is never lost.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; the reset state SHALL be IDLE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid, the block SHALL latch x, p and cnt=k and go to RUN if k!=0, else to DONE.
REQ-017 RUN: in_ready=0, out_valid=0; each cycle the block SHALL replace x with half(x) and decrement cnt; the cycle that takes cnt from 1 to 0 SHALL also move the FSM to DONE.
REQ-018 DONE: out_valid=1, out_data=latched x, in_ready=0; on out_ready=1 the block SHALL go to IDLE; while out_ready=0 out_data and out_valid SHALL hold unchanged.
REQ-019 Latency: input accepted on edge T -> out_valid high from edge T+k+1; k=0 -> out_valid high from edge T+1 with out_data = x unchanged.
REQ-020 Throughput: one operation per k+2 cycles minimum; in_ready SHALL be high only in IDLE, so no input is accepted in the cycle a result is consumed.
REQ-021 in_data, in_p and in_k SHALL be sampled only on the accepting edge; later changes SHALL NOT affect an operation in flight.
REQ-022 out_data SHALL be driven from a register (no combinational path from inputs to out_data or out_valid).
REQ-023 The halving count SHALL be treated as unsigned; k = 2^CW-1 SHALL complete normally with no counter wrap.

Reset
REQ-024 On a clock edge with rst_n=0, the block SHALL enter IDLE, clear x, p and cnt to 0, and drive out_valid=0, out_data=0, in_ready=1 from the following cycle.
REQ-025 Reset asserted during RUN or DONE SHALL discard the operation in flight, with no result emitted afterwards.
REQ-026 An in_valid present in the same cycle as rst_n=0 SHALL NOT be accepted.

Verification
REQ-027 p=17, x=5, k=1 -> out_data=11, out_valid first high 2 cycles after acceptance.
REQ-028 p=17, x=1, k=4 -> successive internal values 9, 13, 15, 16; out_data=16 (16*16 mod 17 = 1), valid 5 cycles after acceptance.
REQ-029 DW=32, p=0xFFFFFFFF, x=0xFFFFFFFD, k=1 -> out_data=0xFFFFFFFE (carry bit exercised).
REQ-030 p=17, x=7, k=0 -> out_data=7, valid 1 cycle after acceptance; out_ready held low 3 cycles -> out_valid and out_data stable, in_ready=0 throughout.
REQ-031 Reset pulsed for one cycle mid-RUN (p=17, x=1, k=4, after 2 halvings) -> next cycle in_ready=1, out_valid=0, out_data=0; no result is ever produced for the aborted operation.
REQ-032 Back-to-back random operations (odd p < 2^DW, x < p, random k, random out_ready) -> each out_data * 2^k mod p == x, and results appear in acceptance order.
